// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: state encodings, opcodes,
// ALU function codes, mux selects and the control-bundle payload.
package cu_pkg;

  localparam int unsigned IR_W   = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 2;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_Z = 3;

  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_F0  = 3'd1,
    S_F1  = 3'd2,
    S_E0  = 3'd3,
    S_E1  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LSL = 4'hA;
  localparam logic [3:0] OP_LSR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_BRA = 4'hE;
  localparam logic [3:0] OP_BCC = 4'hF;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_NOT    = 4'b0010;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_LSL    = 4'b1011;
  localparam logic [3:0] ALU_LSR    = 4'b1100;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IR  = 2'b10;

  localparam logic [1:0] FUN_CLEAR = 2'b00;
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_DEC   = 2'b10;
  localparam logic [1:0] FUN_INC   = 2'b11;

  localparam logic [1:0] ARF_AR = 2'd0;
  localparam logic [1:0] ARF_PC = 2'd3;

  localparam logic [3:0] EN_NONE    = 4'b1111;
  localparam logic [3:0] EN_ALL     = 4'b0000;
  localparam logic [3:0] ARF_EN_PC  = 4'b1110;
  localparam logic [3:0] ARF_EN_AR  = 4'b1101;
  localparam logic [3:0] ARF_EN_RST = 4'b1000;

  localparam logic [2:0] RF_SEL_BASE = 3'd4;

  typedef struct packed {
    logic [2:0] rf_outa_sel;
    logic [2:0] rf_outb_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  // Idle bundle: nothing enabled, memory deselected, all selects zero.
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c              = '0;
    c.rf_rsel      = EN_NONE;
    c.rf_tsel      = EN_NONE;
    c.arf_reg_sel  = EN_NONE;
    c.mem_cs       = 1'b1;
    c.mem_wr       = 1'b0;
    c.ir_enable    = 1'b0;
    return c;
  endfunction

  // Register field n (0..3) addresses Rn+1, which the RF reads at select 4+n.
  function automatic logic [2:0] rf_sel(input logic [REG_W-1:0] idx);
    return RF_SEL_BASE + 3'(idx);
  endfunction

  function automatic logic [3:0] rf_en(input logic [REG_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] alu_code(input logic [OP_W-1:0] op);
    logic [3:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_XOR:  code = ALU_XOR;
      OP_NOT:  code = ALU_NOT;
      OP_LSL:  code = ALU_LSL;
      OP_LSR:  code = ALU_LSR;
      default: code = ALU_PASS_A;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational output decode: maps the current state and instruction fields
// to the full datapath control bundle.
module cu_decoder
  import cu_pkg::*;
(
  input  state_t           state,
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] src,
  input  logic             cond_ne,
  input  logic             z,
  output ctrl_t            ctrl
);

  logic branch_taken;

  // IR[11] picks BNE over BEQ.
  assign branch_taken = cond_ne ? ~z : z;

  always_comb begin
    ctrl = ctrl_default();
    case (state)
      S_RST: begin
        ctrl.rf_fun_sel  = FUN_CLEAR;
        ctrl.rf_rsel     = EN_ALL;
        ctrl.rf_tsel     = EN_ALL;
        ctrl.arf_fun_sel = FUN_CLEAR;
        ctrl.arf_reg_sel = ARF_EN_RST;
      end

      S_F0, S_F1: begin
        ctrl.arf_outd_sel = ARF_PC;
        ctrl.mem_cs       = 1'b0;
        ctrl.mem_wr       = 1'b0;
        ctrl.ir_enable    = 1'b1;
        ctrl.ir_funsel    = FUN_LOAD;
        ctrl.ir_lh        = (state == S_F1);
        ctrl.arf_reg_sel  = ARF_EN_PC;
        ctrl.arf_fun_sel  = FUN_INC;
      end

      S_E0: begin
        case (op)
          OP_LDI: begin
            ctrl.mux_a_sel  = MUX_IR;
            ctrl.rf_fun_sel = FUN_LOAD;
            ctrl.rf_rsel    = rf_en(dst);
          end
          OP_LD, OP_ST: begin
            ctrl.mux_b_sel   = MUX_IR;
            ctrl.arf_reg_sel = ARF_EN_AR;
            ctrl.arf_fun_sel = FUN_LOAD;
          end
          OP_MOV: begin
            ctrl.rf_outa_sel = rf_sel(src);
            ctrl.mux_c_sel   = 1'b1;
            ctrl.alu_fun_sel = ALU_PASS_A;
            ctrl.mux_a_sel   = MUX_ALU;
            ctrl.rf_fun_sel  = FUN_LOAD;
            ctrl.rf_rsel     = rf_en(dst);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl.rf_outa_sel = rf_sel(dst);
            ctrl.rf_outb_sel = rf_sel(src);
            ctrl.mux_c_sel   = 1'b1;
            ctrl.alu_fun_sel = alu_code(op);
            ctrl.mux_a_sel   = MUX_ALU;
            ctrl.rf_fun_sel  = FUN_LOAD;
            ctrl.rf_rsel     = rf_en(dst);
          end
          OP_NOT, OP_LSL, OP_LSR: begin
            ctrl.rf_outa_sel = rf_sel(src);
            ctrl.mux_c_sel   = 1'b1;
            ctrl.alu_fun_sel = alu_code(op);
            ctrl.mux_a_sel   = MUX_ALU;
            ctrl.rf_fun_sel  = FUN_LOAD;
            ctrl.rf_rsel     = rf_en(dst);
          end
          OP_INC, OP_DEC: begin
            ctrl.rf_fun_sel = (op == OP_INC) ? FUN_INC : FUN_DEC;
            ctrl.rf_rsel    = rf_en(dst);
          end
          OP_BRA: begin
            ctrl.mux_b_sel   = MUX_IR;
            ctrl.arf_reg_sel = ARF_EN_PC;
            ctrl.arf_fun_sel = FUN_LOAD;
          end
          OP_BCC: begin
            if (branch_taken) begin
              ctrl.mux_b_sel   = MUX_IR;
              ctrl.arf_reg_sel = ARF_EN_PC;
              ctrl.arf_fun_sel = FUN_LOAD;
            end
          end
          default: ;
        endcase
      end

      // Second execute cycle: memory access through AR.
      S_E1: begin
        if (op == OP_LD) begin
          ctrl.arf_outd_sel = ARF_AR;
          ctrl.mem_cs       = 1'b0;
          ctrl.mux_a_sel    = MUX_MEM;
          ctrl.rf_fun_sel   = FUN_LOAD;
          ctrl.rf_rsel      = rf_en(dst);
        end else if (op == OP_ST) begin
          ctrl.arf_outd_sel = ARF_AR;
          ctrl.rf_outa_sel  = rf_sel(src);
          ctrl.mux_c_sel    = 1'b1;
          ctrl.alu_fun_sel  = ALU_PASS_A;
          ctrl.mem_cs       = 1'b0;
          ctrl.mem_wr       = 1'b1;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for the ALU_System datapath: two-byte fetch, then one
// or two execute cycles. Outputs are a combinational decode of the state.
module control_unit
  import cu_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [IR_W-1:0]   IROut,
  input  logic [FLAG_W-1:0] ALUOutFlag,
  output logic [2:0]        RF_OutASel,
  output logic [2:0]        RF_OutBSel,
  output logic [1:0]        RF_FunSel,
  output logic [3:0]        RF_RSel,
  output logic [3:0]        RF_TSel,
  output logic [3:0]        ALU_FunSel,
  output logic [1:0]        ARF_OutCSel,
  output logic [1:0]        ARF_OutDSel,
  output logic [1:0]        ARF_FunSel,
  output logic [3:0]        ARF_RegSel,
  output logic              IR_LH,
  output logic              IR_Enable,
  output logic [1:0]        IR_Funsel,
  output logic              Mem_WR,
  output logic              Mem_CS,
  output logic [1:0]        MuxASel,
  output logic [1:0]        MuxBSel,
  output logic              MuxCSel,
  output logic [2:0]        State
);

  state_t          state;
  state_t          state_nxt;
  ctrl_t           ctrl;
  logic [OP_W-1:0] op;
  logic            unused_bits;

  assign op          = IROut[15:12];
  // The address byte goes straight to the datapath; C/N/O are never branched on.
  assign unused_bits = ^{IROut[7:0], ALUOutFlag[2:0]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:   state_nxt = S_F0;
      S_F0:    state_nxt = S_F1;
      S_F1:    state_nxt = S_E0;
      S_E0:    state_nxt = (op == OP_LD || op == OP_ST) ? S_E1 : S_F0;
      S_E1:    state_nxt = S_F0;
      default: state_nxt = S_RST;
    endcase
  end

  cu_decoder u_decoder (
    .state   (state),
    .op      (op),
    .dst     (IROut[11:10]),
    .src     (IROut[9:8]),
    .cond_ne (IROut[11]),
    .z       (ALUOutFlag[FLAG_Z]),
    .ctrl    (ctrl)
  );

  assign RF_OutASel  = ctrl.rf_outa_sel;
  assign RF_OutBSel  = ctrl.rf_outb_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_RSel     = ctrl.rf_rsel;
  assign RF_TSel     = ctrl.rf_tsel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ARF_OutCSel = ctrl.arf_outc_sel;
  assign ARF_OutDSel = ctrl.arf_outd_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_Funsel   = ctrl.ir_funsel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign State       = state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: decode table at S_E0 plus short programs run
// through a small behavioural model of the 8-bit datapath and memory.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  State;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
    .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .State(State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Datapath model
  logic        use_model;
  logic [15:0] ir_drv;
  logic        flag_z;
  logic        ld_en;
  logic [7:0]  ld_addr, ld_data;
  logic [7:0]  mem [256];
  logic [15:0] ir_q;
  logic [7:0]  rf_r [4];
  logic [7:0]  rf_t [4];
  logic [7:0]  pc, ar, sp;
  logic [7:0]  o1, o2, alu_a, alu_out, outc, mem_addr, mem_out, mux_a_out, mux_b_out;

  assign IROut      = use_model ? ir_q : ir_drv;
  assign ALUOutFlag = {flag_z, 3'b000};

  function automatic logic [7:0] rd_rf(input logic [2:0] sel);
    return sel[2] ? rf_r[sel[1:0]] : rf_t[sel[1:0]];
  endfunction

  function automatic logic [7:0] rd_arf(input logic [1:0] sel);
    case (sel)
      2'd0:    return ar;
      2'd1:    return sp;
      2'd3:    return pc;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] upd(input logic [7:0] cur, input logic [1:0] fun,
                                     input logic [7:0] din);
    case (fun)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return cur - 8'd1;
      default: return cur + 8'd1;
    endcase
  endfunction

  always_comb begin
    o1       = rd_rf(RF_OutASel);
    o2       = rd_rf(RF_OutBSel);
    outc     = rd_arf(ARF_OutCSel);
    mem_addr = rd_arf(ARF_OutDSel);
    mem_out  = mem[mem_addr];
    alu_a    = MuxCSel ? o1 : outc;
    case (ALU_FunSel)
      4'b0000: alu_out = alu_a;
      4'b0010: alu_out = ~alu_a;
      4'b0100: alu_out = alu_a + o2;
      4'b0101: alu_out = alu_a - o2;
      4'b0111: alu_out = alu_a & o2;
      4'b1000: alu_out = alu_a | o2;
      4'b1010: alu_out = alu_a ^ o2;
      4'b1011: alu_out = alu_a << 1;
      4'b1100: alu_out = alu_a >> 1;
      default: alu_out = 8'h00;
    endcase
    case (MuxASel)
      2'b00:   mux_a_out = alu_out;
      2'b01:   mux_a_out = mem_out;
      2'b10:   mux_a_out = ir_q[7:0];
      default: mux_a_out = outc;
    endcase
    case (MuxBSel)
      2'b00:   mux_b_out = alu_out;
      2'b01:   mux_b_out = mem_out;
      2'b10:   mux_b_out = ir_q[7:0];
      default: mux_b_out = outc;
    endcase
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (!RF_RSel[i]) rf_r[i] <= upd(rf_r[i], RF_FunSel, mux_a_out);
      if (!RF_TSel[i]) rf_t[i] <= upd(rf_t[i], RF_FunSel, mux_a_out);
    end
    if (!ARF_RegSel[0]) pc <= upd(pc, ARF_FunSel, mux_b_out);
    if (!ARF_RegSel[1]) ar <= upd(ar, ARF_FunSel, mux_b_out);
    if (!ARF_RegSel[2]) sp <= upd(sp, ARF_FunSel, mux_b_out);
    if (IR_Enable && IR_Funsel == 2'b01) begin
      if (IR_LH) ir_q[15:8] <= mem_out;
      else       ir_q[7:0]  <= mem_out;
    end
    if (ld_en)                 mem[ld_addr]  <= ld_data;
    else if (!Mem_CS && Mem_WR) mem[mem_addr] <= alu_out;
  end

  // Checking
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    step();
    ld_en   = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ir;
    logic        z;
    logic [3:0]  rsel;
    logic [3:0]  alu;
    logic [3:0]  arf;
    logic [1:0]  mux_a;
    logic [1:0]  mux_b;
    logic [2:0]  outa;
    logic [2:0]  outb;
    logic [1:0]  rf_fun;
    logic [2:0]  nxt;
  } vec_t;

  vec_t vecs [19];

  initial begin
    Reset = 1'b1; use_model = 1'b0; ir_drv = 16'h0000; flag_z = 1'b0;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;

    //              ir       z     rsel     alu      arf      ma     mb     oa    ob    fun    nxt
    vecs[0]  = '{16'h0812, 1'b0, 4'b1011, 4'b0000, 4'b1111, 2'b10, 2'b00, 3'd0, 3'd0, 2'b01, 3'd1}; // LDI R3
    vecs[1]  = '{16'h1033, 1'b0, 4'b1111, 4'b0000, 4'b1101, 2'b00, 2'b10, 3'd0, 3'd0, 2'b00, 3'd4}; // LD
    vecs[2]  = '{16'h2380, 1'b0, 4'b1111, 4'b0000, 4'b1101, 2'b00, 2'b10, 3'd0, 3'd0, 2'b00, 3'd4}; // ST
    vecs[3]  = '{16'h3700, 1'b0, 4'b1101, 4'b0000, 4'b1111, 2'b00, 2'b00, 3'd7, 3'd0, 2'b01, 3'd1}; // MOV R2,R4
    vecs[4]  = '{16'h4C00, 1'b0, 4'b0111, 4'b0100, 4'b1111, 2'b00, 2'b00, 3'd7, 3'd4, 2'b01, 3'd1}; // ADD R4,R1
    vecs[5]  = '{16'h5100, 1'b0, 4'b1110, 4'b0101, 4'b1111, 2'b00, 2'b00, 3'd4, 3'd5, 2'b01, 3'd1}; // SUB R1,R2
    vecs[6]  = '{16'h6000, 1'b0, 4'b1110, 4'b0111, 4'b1111, 2'b00, 2'b00, 3'd4, 3'd4, 2'b01, 3'd1}; // AND R1,R1
    vecs[7]  = '{16'h7900, 1'b0, 4'b1011, 4'b1000, 4'b1111, 2'b00, 2'b00, 3'd6, 3'd5, 2'b01, 3'd1}; // OR R3,R2
    vecs[8]  = '{16'h8600, 1'b0, 4'b1101, 4'b1010, 4'b1111, 2'b00, 2'b00, 3'd5, 3'd6, 2'b01, 3'd1}; // XOR R2,R3
    vecs[9]  = '{16'h9300, 1'b0, 4'b1110, 4'b0010, 4'b1111, 2'b00, 2'b00, 3'd7, 3'd0, 2'b01, 3'd1}; // NOT R1,R4
    vecs[10] = '{16'hA800, 1'b0, 4'b1011, 4'b1011, 4'b1111, 2'b00, 2'b00, 3'd4, 3'd0, 2'b01, 3'd1}; // LSL R3,R1
    vecs[11] = '{16'hBD00, 1'b0, 4'b0111, 4'b1100, 4'b1111, 2'b00, 2'b00, 3'd5, 3'd0, 2'b01, 3'd1}; // LSR R4,R2
    vecs[12] = '{16'hC400, 1'b0, 4'b1101, 4'b0000, 4'b1111, 2'b00, 2'b00, 3'd0, 3'd0, 2'b11, 3'd1}; // INC R2
    vecs[13] = '{16'hDC00, 1'b0, 4'b0111, 4'b0000, 4'b1111, 2'b00, 2'b00, 3'd0, 3'd0, 2'b10, 3'd1}; // DEC R4
    vecs[14] = '{16'hE07F, 1'b0, 4'b1111, 4'b0000, 4'b1110, 2'b00, 2'b10, 3'd0, 3'd0, 2'b00, 3'd1}; // BRA
    vecs[15] = '{16'hF810, 1'b0, 4'b1111, 4'b0000, 4'b1110, 2'b00, 2'b10, 3'd0, 3'd0, 2'b00, 3'd1}; // BNE taken
    vecs[16] = '{16'hF810, 1'b1, 4'b1111, 4'b0000, 4'b1111, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 3'd1}; // BNE not taken
    vecs[17] = '{16'hF010, 1'b0, 4'b1111, 4'b0000, 4'b1111, 2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 3'd1}; // BEQ not taken
    vecs[18] = '{16'hF010, 1'b1, 4'b1111, 4'b0000, 4'b1110, 2'b00, 2'b10, 3'd0, 3'd0, 2'b00, 3'd1}; // BEQ taken

    for (int i = 0; i < 19; i++) begin
      Reset  = 1'b1;
      ir_drv = vecs[i].ir;
      flag_z = vecs[i].z;
      step();
      Reset = 1'b0;
      step(); step(); step();
      check($sformatf("vec%0d_e0", i),
            32'({RF_RSel, ALU_FunSel, ARF_RegSel, MuxASel, MuxBSel, RF_OutASel, RF_OutBSel, RF_FunSel}),
            32'({vecs[i].rsel, vecs[i].alu, vecs[i].arf, vecs[i].mux_a, vecs[i].mux_b,
                 vecs[i].outa, vecs[i].outb, vecs[i].rf_fun}));
      step();
      check($sformatf("vec%0d_next", i), 32'(State), 32'(vecs[i].nxt));
    end

    // Program run through the datapath model
    use_model = 1'b1;
    flag_z    = 1'b1;
    Reset     = 1'b1;
    load(8'h00, 8'h2A); load(8'h01, 8'h04);   // LDI R2,0x2A
    load(8'h02, 8'h05); load(8'h03, 8'h00);   // LDI R1,5
    load(8'h04, 8'h03); load(8'h05, 8'h04);   // LDI R2,3
    load(8'h06, 8'h00); load(8'h07, 8'h51);   // SUB R1,R2
    load(8'h08, 8'h77); load(8'h09, 8'h00);   // LDI R1,0x77
    load(8'h0A, 8'h80); load(8'h0B, 8'h20);   // ST R1 -> 0x80
    load(8'h0C, 8'h80); load(8'h0D, 8'h18);   // LD R3 <- 0x80
    load(8'h0E, 8'h40); load(8'h0F, 8'hF0);   // BEQ 0x40
    load(8'h40, 8'h40); load(8'h41, 8'hE0);   // BRA 0x40 (self loop)
    check("rst_outputs", 32'({RF_RSel, RF_TSel, ARF_RegSel, Mem_CS, State}),
          32'({4'b0000, 4'b0000, 4'b1000, 1'b1, 3'd0}));
    Reset = 1'b0;
    step();
    check("f0_state", 32'(State), 32'd1);
    check("f0_outputs", 32'({IR_Enable, IR_LH, IR_Funsel, ARF_RegSel, ARF_FunSel, ARF_OutDSel, Mem_CS, Mem_WR}),
          32'({1'b1, 1'b0, 2'b01, 4'b1110, 2'b11, 2'b11, 1'b0, 1'b0}));
    step();
    check("f1_state", 32'(State), 32'd2);
    check("f1_lh", 32'(IR_LH), 32'd1);
    step();
    check("e0_state", 32'(State), 32'd3);
    step();
    check("ldi_r2", 32'(rf_r[1]), 32'h2A);
    check("ldi_pc", 32'(pc), 32'h02);
    step(); step(); step();
    step(); step(); step();
    step(); step();
    check("sub_e0", 32'({ALU_FunSel, RF_RSel}), 32'({4'b0101, 4'b1110}));
    step();
    check("sub_r1", 32'(rf_r[0]), 32'h02);
    step(); step(); step();
    check("st_f0_wr", 32'(Mem_WR), 32'd0);
    step();
    check("st_f1_wr", 32'(Mem_WR), 32'd0);
    step();
    check("st_e0_wr", 32'({State, Mem_WR}), 32'({3'd3, 1'b0}));
    step();
    check("st_e1_wr", 32'({State, Mem_WR, Mem_CS}), 32'({3'd4, 1'b1, 1'b0}));
    step();
    check("st_done", 32'(State), 32'd1);
    check("st_mem", 32'(mem[8'h80]), 32'h77);
    step(); step(); step();
    check("ld_e1", 32'({State, Mem_WR, Mem_CS}), 32'({3'd4, 1'b0, 1'b0}));
    step();
    check("ld_done", 32'(State), 32'd1);
    check("ld_r3", 32'(rf_r[2]), 32'h77);
    step(); step(); step();
    check("beq_taken_pc", 32'(pc), 32'h40);
    step(); step(); step();
    check("bra_self_pc1", 32'(pc), 32'h40);
    step(); step(); step();
    check("bra_self_pc2", 32'(pc), 32'h40);

    // BEQ not taken
    flag_z = 1'b0;
    Reset  = 1'b1;
    load(8'h00, 8'h40); load(8'h01, 8'hF0);
    Reset = 1'b0;
    step(); step(); step();
    check("beq_nt_e0", 32'({State, ARF_RegSel, MuxBSel}), 32'({3'd3, 4'b1111, 2'b00}));
    step();
    check("beq_nt_pc", 32'(pc), 32'h02);

    // Reset in the middle of a store
    Reset = 1'b1;
    load(8'h00, 8'h55); load(8'h01, 8'h00);   // LDI R1,0x55
    load(8'h02, 8'h90); load(8'h03, 8'h20);   // ST R1 -> 0x90
    load(8'h90, 8'h11);
    Reset = 1'b0;
    step(); step(); step(); step(); step(); step(); step();
    check("abort_pre", 32'({State, Mem_CS, Mem_WR}), 32'({3'd4, 1'b0, 1'b1}));
    Reset = 1'b1;
    #1;
    check("abort_cs", 32'({State, Mem_CS}), 32'({3'd0, 1'b1}));
    step();
    Reset = 1'b0;
    check("abort_mem", 32'(mem[8'h90]), 32'h11);
    step();
    check("abort_restart", 32'(State), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
